config_transactor: RTL and testbench
====================================

Name: config_transactor

Overview:
- Synthesizable configuration loader for the `nn` array.
- Holds neuron, dendrite and synapse parameter words in an internal register file written by a host port.
- On command, serializes the words onto NUM_SYNAPSE_ROWS+1 serial config chains:
  - chains 0..NUM_SYNAPSE_ROWS-1 carry synapse/dendrite rows;
  - chain NUM_SYNAPSE_ROWS carries the neuron row.

Parameters:
- NUM_SYNAPSE_ROWS, 2, number of synapse/dendrite chains.
- NUM_COLS, 2, neuron columns; each column has 2 synapses per row.
- WEIGHT_WIDTH, 6, bits per parameter word.
- SYN_FIELDS, 3, words per synapse.
- DEND_FIELDS, 1, words per dendrite (one per row and column).
- NEURON_FIELDS, 2, words per neuron.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  register-file write strobe.
- wr_sel  in  2  target: 0 = synapse, 1 = dendrite, 2 = neuron, 3 = reserved.
- wr_row  in  max(1,clog2(NUM_SYNAPSE_ROWS))  row; ignored for neuron.
- wr_col  in  max(1,clog2(2*NUM_COLS))  synapse index (0..2*NUM_COLS-1), or column for dendrite/neuron.
- wr_field  in  2  field index.
- wr_data  in  WEIGHT_WIDTH  word value.
- start_syn  in  1  pulse: shift synapse+dendrite chains.
- start_neuron  in  1  pulse: shift neuron chain.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse at completion.
- cfg_data  out  NUM_SYNAPSE_ROWS+1  serial data per chain.
- cfg_shift  out  NUM_SYNAPSE_ROWS+1  bit-valid/shift enable per chain.
- cfg_load  out  NUM_SYNAPSE_ROWS+1  one-cycle latch pulse per chain.

Behaviour:
- Reset (async, reset_n low):
  - all register-file words = 0;
  - FSM = IDLE;
  - busy, done, cfg_data, cfg_shift, cfg_load = 0.
- Writes:
  - Registered on the clk edge when wr_en=1 and busy=0.
  - Writes with wr_sel=3 or an out-of-range row/col/field are ignored.
  - Writes while busy are ignored.
- FSM states: IDLE → SHIFT → LOAD → DONE → IDLE.
- IDLE:
  - start_syn=1 → SHIFT with target set = chains 0..NUM_SYNAPSE_ROWS-1 (all rows in parallel).
  - else start_neuron=1 → SHIFT with target = chain NUM_SYNAPSE_ROWS.
  - If both are asserted, start_syn wins and start_neuron is dropped.
  - Starts are ignored when not in IDLE.
- SHIFT:
  - One bit per cycle; cfg_shift=1 on the target chains only.
  - First bit appears the cycle after the start pulse.
  - Row-chain length: NUM_COLS*(DEND_FIELDS+2*SYN_FIELDS)*WEIGHT_WIDTH bits (84 at defaults).
  - Neuron-chain length: NUM_COLS*NEURON_FIELDS*WEIGHT_WIDTH bits (24 at defaults).
- Stream order (last-in-chain element first), words MSB first:
  - Row chain: for col c = NUM_COLS-1 down to 0:
    - dendrite(c) fields high→low;
    - synapse 2c+1 fields high→low;
    - synapse 2c fields high→low.
  - Neuron chain: col high→low, fields high→low.
- Non-target chains: cfg_data=0, cfg_shift=0.
- LOAD: cfg_load=1 for one cycle on the target chains; cfg_shift=0.
- DONE: done=1 for one cycle; busy falls in the same cycle. busy is high from the first SHIFT cycle through LOAD.
- Total latency: start → done = bits+2 cycles.
- Reset asserted mid-shift aborts immediately. No cfg_load or done is issued.

Optional Feature:
- CFG_READBACK_EN defined:
  - Adds input rd_en and output rd_data (WEIGHT_WIDTH).
  - Address comes from wr_sel/wr_row/wr_col/wr_field.
  - rd_data is registered one cycle after rd_en and holds until the next read.
  - Invalid address reads 0.
  - Reads are allowed while busy.
- Undefined: the rd_en/rd_data ports and the read logic are absent.

Decomposition:
- Package cfg_pkg:
  - target enum (SYN=0, DEND=1, NEURON=2);
  - field-count constants and word width;
  - FSM state enum;
  - chain-length functions.
- One sub-module, cfg_serializer: bit/word counters and MSB-first word-to-bit mux. It is instantiated once and drives the selected chains.

Test Plan:
- Neuron chain:
  - Stimulus: write neuron (col0,f0)=1, (col1,f0)=2; start_neuron.
  - Required: 24 shift cycles on chain 2 only. Stream = col1 f1=0, col1 f0=000010, col0 f1=0, col0 f0=000001. Then cfg_load[2] pulse, then done; total 26 cycles.
- Synapse chains:
  - Stimulus: write row0 synapses 0..3 fields = 1..12 and row1 = 16..27; start_syn.
  - Required: chains 0 and 1 each shift 84 bits in parallel. Row0 stream starts dend(1)=0, then syn3 f2=12 (001100), f1=11, f0=10. Ends with syn0 f0=000001.
- Start priority: start_syn and start_neuron in the same cycle → only chains 0..1 shift. A start_neuron pulse during busy is ignored.
- Write guard: write wr_data=63 during busy, then rerun start_neuron → stream unchanged. Write with wr_sel=3 → no effect.
- Reset mid-operation: drop reset_n at bit 40 of a synapse shift → all outputs 0 at once, no cfg_load/done. A subsequent shift streams all zeros.
- CFG_READBACK_EN: write synapse (1,3,2)=27; read → rd_data=27 one cycle later. Read of an invalid field → 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types, field counts and chain-length helpers for config_transactor
package cfg_pkg;

  localparam int DEF_NUM_SYNAPSE_ROWS = 2;
  localparam int DEF_NUM_COLS         = 2;
  localparam int DEF_WEIGHT_WIDTH     = 6;

  localparam int SYN_FIELDS    = 3;
  localparam int DEND_FIELDS   = 1;
  localparam int NEURON_FIELDS = 2;
  // Words per column on a row chain: one dendrite plus two synapses.
  localparam int ROW_WORDS     = DEND_FIELDS + 2 * SYN_FIELDS;

  typedef enum logic [1:0] {
    SYN    = 2'd0,
    DEND   = 2'd1,
    NEURON = 2'd2
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int row_chain_len(input int num_cols, input int weight_width);
    return num_cols * ROW_WORDS * weight_width;
  endfunction

  function automatic int neuron_chain_len(input int num_cols, input int weight_width);
    return num_cols * NEURON_FIELDS * weight_width;
  endfunction

endpackage

// File: rtl/config_transactor_if.sv
// rtl/config_transactor_if.sv - host write/start port and serial chain outputs; CFG_READBACK_EN adds rd_en/rd_data
interface config_transactor_if #(
  parameter int NUM_SYNAPSE_ROWS = cfg_pkg::DEF_NUM_SYNAPSE_ROWS,
  parameter int NUM_COLS         = cfg_pkg::DEF_NUM_COLS,
  parameter int WEIGHT_WIDTH     = cfg_pkg::DEF_WEIGHT_WIDTH
);
  localparam int RW  = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1;
  localparam int CW  = (2 * NUM_COLS > 1) ? $clog2(2 * NUM_COLS) : 1;
  localparam int NCH = NUM_SYNAPSE_ROWS + 1;

  logic                    wr_en;
  logic [1:0]              wr_sel;
  logic [RW-1:0]           wr_row;
  logic [CW-1:0]           wr_col;
  logic [1:0]              wr_field;
  logic [WEIGHT_WIDTH-1:0] wr_data;
  logic                    start_syn;
  logic                    start_neuron;
  logic                    busy;
  logic                    done;
  logic [NCH-1:0]          cfg_data;
  logic [NCH-1:0]          cfg_shift;
  logic [NCH-1:0]          cfg_load;
`ifdef CFG_READBACK_EN
  logic                    rd_en;
  logic [WEIGHT_WIDTH-1:0] rd_data;
`endif

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_field, wr_data, start_syn, start_neuron,
    input  busy, done, cfg_data, cfg_shift, cfg_load
`ifdef CFG_READBACK_EN
    , output rd_en
    , input  rd_data
`endif
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_field, wr_data, start_syn, start_neuron,
    output busy, done, cfg_data, cfg_shift, cfg_load
`ifdef CFG_READBACK_EN
    , input  rd_en
    , output rd_data
`endif
  );

endinterface

// File: rtl/cfg_serializer.sv
// rtl/cfg_serializer.sv - bit/word/column counters and MSB-first word-to-bit mux shared by all chains
module cfg_serializer
  import cfg_pkg::*;
#(
  parameter  int NUM_CHAINS   = 3,
  parameter  int NUM_COLS     = 2,
  parameter  int WEIGHT_WIDTH = 6,
  localparam int GW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int SW = $clog2(ROW_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_i,
  input  logic                    neuron_i,
  input  logic                    advance_i,
  input  logic [WEIGHT_WIDTH-1:0] word_i [NUM_CHAINS],
  output logic [GW-1:0]           grp_o,
  output logic [SW-1:0]           slot_o,
  output logic [NUM_CHAINS-1:0]   bit_o,
  output logic                    last_o
);
  localparam int BW = (WEIGHT_WIDTH > 1) ? $clog2(WEIGHT_WIDTH) : 1;
  localparam int LW = $clog2(row_chain_len(NUM_COLS, WEIGHT_WIDTH) + 1);

  logic          neuron_q;
  logic [BW-1:0] bit_q;
  logic [SW-1:0] slot_q;
  logic [GW-1:0] grp_q;
  logic [LW-1:0] rem_q;
  logic [SW-1:0] last_slot;

  assign last_slot = neuron_q ? SW'(NEURON_FIELDS - 1) : SW'(ROW_WORDS - 1);

  // Columns are walked from the highest down so the far end of the chain goes out first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neuron_q <= 1'b0;
      bit_q    <= '0;
      slot_q   <= '0;
      grp_q    <= '0;
      rem_q    <= '0;
    end else if (start_i) begin
      neuron_q <= neuron_i;
      bit_q    <= BW'(WEIGHT_WIDTH - 1);
      slot_q   <= '0;
      grp_q    <= GW'(NUM_COLS - 1);
      rem_q    <= neuron_i ? LW'(neuron_chain_len(NUM_COLS, WEIGHT_WIDTH))
                           : LW'(row_chain_len(NUM_COLS, WEIGHT_WIDTH));
    end else if (advance_i) begin
      rem_q <= rem_q - LW'(1);
      if (bit_q == '0) begin
        bit_q <= BW'(WEIGHT_WIDTH - 1);
        if (slot_q == last_slot) begin
          slot_q <= '0;
          grp_q  <= grp_q - GW'(1);
        end else begin
          slot_q <= slot_q + SW'(1);
        end
      end else begin
        bit_q <= bit_q - BW'(1);
      end
    end
  end

  always_comb begin
    bit_o = '0;
    for (int ch = 0; ch < NUM_CHAINS; ch++) begin
      bit_o[ch] = word_i[ch][bit_q];
    end
  end

  assign grp_o  = grp_q;
  assign slot_o = slot_q;
  assign last_o = (rem_q == LW'(1));

endmodule

// File: rtl/config_transactor.sv
// rtl/config_transactor.sv - parameter register file and serial chain loader for the nn array
// Optional readback port enabled by defining CFG_READBACK_EN.
module config_transactor
  import cfg_pkg::*;
#(
  parameter int NUM_SYNAPSE_ROWS = DEF_NUM_SYNAPSE_ROWS,
  parameter int NUM_COLS         = DEF_NUM_COLS,
  parameter int WEIGHT_WIDTH     = DEF_WEIGHT_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  config_transactor_if.slave  bus
);
  localparam int NCH = NUM_SYNAPSE_ROWS + 1;
  localparam int GW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int SW  = $clog2(ROW_WORDS + 1);
  localparam logic [NCH-1:0] ROW_MASK = {1'b0, {NUM_SYNAPSE_ROWS{1'b1}}};
  localparam logic [NCH-1:0] NEU_MASK = {1'b1, {NUM_SYNAPSE_ROWS{1'b0}}};

  logic [WEIGHT_WIDTH-1:0] syn_q  [NUM_SYNAPSE_ROWS][2*NUM_COLS][SYN_FIELDS];
  logic [WEIGHT_WIDTH-1:0] dend_q [NUM_SYNAPSE_ROWS][NUM_COLS][DEND_FIELDS];
  logic [WEIGHT_WIDTH-1:0] neu_q  [NUM_COLS][NEURON_FIELDS];

  state_e         state_q, state_d;
  logic [NCH-1:0] tgt_q, tgt_d;
  logic           busy, wr_ok;
  logic           sel_syn, sel_dend, sel_neu;
  logic           ser_start, ser_neuron, ser_last;
  logic [GW-1:0]  ser_grp;
  logic [SW-1:0]  ser_slot;
  logic [NCH-1:0] ser_bits;
  logic [WEIGHT_WIDTH-1:0] chain_word [NCH];

  assign busy     = (state_q == ST_SHIFT) || (state_q == ST_LOAD);
  assign wr_ok    = bus.wr_en && !busy;
  assign sel_syn  = (bus.wr_sel == SYN);
  assign sel_dend = (bus.wr_sel == DEND);
  assign sel_neu  = (bus.wr_sel == NEURON);

  // Only in-range addresses match a loop index, so invalid writes fall through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
        for (int i = 0; i < 2*NUM_COLS; i++)
          for (int f = 0; f < SYN_FIELDS; f++) syn_q[r][i][f] <= '0;
        for (int c = 0; c < NUM_COLS; c++)
          for (int f = 0; f < DEND_FIELDS; f++) dend_q[r][c][f] <= '0;
      end
      for (int c = 0; c < NUM_COLS; c++)
        for (int f = 0; f < NEURON_FIELDS; f++) neu_q[c][f] <= '0;
    end else if (wr_ok) begin
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
        for (int i = 0; i < 2*NUM_COLS; i++)
          for (int f = 0; f < SYN_FIELDS; f++)
            if (sel_syn && int'(bus.wr_row) == r && int'(bus.wr_col) == i && int'(bus.wr_field) == f)
              syn_q[r][i][f] <= bus.wr_data;
        for (int c = 0; c < NUM_COLS; c++)
          for (int f = 0; f < DEND_FIELDS; f++)
            if (sel_dend && int'(bus.wr_row) == r && int'(bus.wr_col) == c && int'(bus.wr_field) == f)
              dend_q[r][c][f] <= bus.wr_data;
      end
      for (int c = 0; c < NUM_COLS; c++)
        for (int f = 0; f < NEURON_FIELDS; f++)
          if (sel_neu && int'(bus.wr_col) == c && int'(bus.wr_field) == f)
            neu_q[c][f] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    ser_start  = 1'b0;
    ser_neuron = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_syn) begin
          tgt_d     = ROW_MASK;
          ser_start = 1'b1;
          state_d   = ST_SHIFT;
        end else if (bus.start_neuron) begin
          tgt_d      = NEU_MASK;
          ser_start  = 1'b1;
          ser_neuron = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: if (ser_last) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Row slot order per column: dendrite, odd synapse, even synapse, each field high to low.
  always_comb begin
    for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
      chain_word[r] = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        if (int'(ser_grp) == c) begin
          for (int f = 0; f < DEND_FIELDS; f++)
            if (int'(ser_slot) == DEND_FIELDS - 1 - f) chain_word[r] = dend_q[r][c][f];
          for (int f = 0; f < SYN_FIELDS; f++) begin
            if (int'(ser_slot) == DEND_FIELDS + SYN_FIELDS - 1 - f) chain_word[r] = syn_q[r][2*c+1][f];
            if (int'(ser_slot) == ROW_WORDS - 1 - f)                chain_word[r] = syn_q[r][2*c][f];
          end
        end
      end
    end
    chain_word[NUM_SYNAPSE_ROWS] = '0;
    for (int c = 0; c < NUM_COLS; c++)
      if (int'(ser_grp) == c)
        for (int f = 0; f < NEURON_FIELDS; f++)
          if (int'(ser_slot) == NEURON_FIELDS - 1 - f) chain_word[NUM_SYNAPSE_ROWS] = neu_q[c][f];
  end

  cfg_serializer #(
    .NUM_CHAINS  (NCH),
    .NUM_COLS    (NUM_COLS),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (ser_start),
    .neuron_i (ser_neuron),
    .advance_i(state_q == ST_SHIFT),
    .word_i   (chain_word),
    .grp_o    (ser_grp),
    .slot_o   (ser_slot),
    .bit_o    (ser_bits),
    .last_o   (ser_last)
  );

  assign bus.busy      = busy;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.cfg_shift = (state_q == ST_SHIFT) ? tgt_q : '0;
  assign bus.cfg_data  = (state_q == ST_SHIFT) ? (ser_bits & tgt_q) : '0;
  assign bus.cfg_load  = (state_q == ST_LOAD)  ? tgt_q : '0;

`ifdef CFG_READBACK_EN
  logic [WEIGHT_WIDTH-1:0] rd_word, rd_data_q;

  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
      for (int i = 0; i < 2*NUM_COLS; i++)
        for (int f = 0; f < SYN_FIELDS; f++)
          if (sel_syn && int'(bus.wr_row) == r && int'(bus.wr_col) == i && int'(bus.wr_field) == f)
            rd_word = syn_q[r][i][f];
      for (int c = 0; c < NUM_COLS; c++)
        for (int f = 0; f < DEND_FIELDS; f++)
          if (sel_dend && int'(bus.wr_row) == r && int'(bus.wr_col) == c && int'(bus.wr_field) == f)
            rd_word = dend_q[r][c][f];
    end
    for (int c = 0; c < NUM_COLS; c++)
      for (int f = 0; f < NEURON_FIELDS; f++)
        if (sel_neu && int'(bus.wr_col) == c && int'(bus.wr_field) == f)
          rd_word = neu_q[c][f];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        rd_data_q <= '0;
    else if (bus.rd_en)  rd_data_q <= rd_word;
  end

  assign bus.rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_config_transactor.sv
// tb/tb_config_transactor.sv - directed self-checking bench for config_transactor (CFG_READBACK_EN optional)
module tb_config_transactor;
  import cfg_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  config_transactor_if bus ();

  config_transactor dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  int           cnt [3];
  logic [127:0] stream [3];
  int           latency, load_k, busy_cnt, bad_nt;
  logic [2:0]   load_mask;

  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_sel = 2'd0; bus.wr_row = 1'b0; bus.wr_col = 2'd0;
    bus.wr_field = 2'd0; bus.wr_data = 6'd0; bus.start_syn = 1'b0; bus.start_neuron = 1'b0;
`ifdef CFG_READBACK_EN
    bus.rd_en = 1'b0;
`endif
  endtask

  task automatic set_addr(input int sel, input int row, input int col, input int fld);
    bus.wr_sel = 2'(sel); bus.wr_row = 1'(row); bus.wr_col = 2'(col); bus.wr_field = 2'(fld);
  endtask

  task automatic write_word(input int sel, input int row, input int col, input int fld, input int d);
    @(negedge clk);
    set_addr(sel, row, col, fld);
    bus.wr_data = 6'(d);
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // inj_kind: 1 = pulse start_neuron, 2 = write 63 to neuron col0 f0, at capture cycle inj_k
  task automatic run_op(input logic s_syn, input logic s_neu, input int inj_k, input int inj_kind);
    int k;
    for (int ch = 0; ch < 3; ch++) begin cnt[ch] = 0; stream[ch] = '0; end
    latency = -1; load_k = -1; busy_cnt = 0; bad_nt = 0; load_mask = '0;
    @(negedge clk);
    bus.start_syn = s_syn;
    bus.start_neuron = s_neu;
    k = 0;
    while (k < 300 && latency < 0) begin
      @(negedge clk);
      k++;
      bus.start_syn = 1'b0; bus.start_neuron = 1'b0; bus.wr_en = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        if (bus.cfg_shift[ch]) begin
          cnt[ch]++;
          stream[ch] = {stream[ch][126:0], bus.cfg_data[ch]};
        end else if (bus.cfg_data[ch]) begin
          bad_nt++;
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.cfg_load != 3'b000) begin load_mask |= bus.cfg_load; load_k = k; end
      if (bus.done) latency = k;
      if (k == inj_k && inj_kind == 1) bus.start_neuron = 1'b1;
      if (k == inj_k && inj_kind == 2) begin
        set_addr(2, 0, 0, 0); bus.wr_data = 6'd63; bus.wr_en = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cfg_data, bus.cfg_shift, bus.cfg_load} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0", {bus.busy, bus.done, bus.cfg_data, bus.cfg_shift, bus.cfg_load});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_neuron();
    write_word(2, 0, 0, 0, 1);
    write_word(2, 0, 1, 0, 2);
    run_op(1'b0, 1'b1, -1, 0);
    checks++;
    if (cnt[0] != 0 || cnt[1] != 0 || cnt[2] != 24) begin
      failures++;
      $display("FAIL neuron_shift_counts: got %0d/%0d/%0d want 0/0/24", cnt[0], cnt[1], cnt[2]);
    end
    checks++;
    if (stream[2][23:0] !== 24'h002001) begin
      failures++;
      $display("FAIL neuron_stream: got %h want 002001", stream[2][23:0]);
    end
    checks++;
    if (load_mask !== 3'b100 || load_k != 25) begin
      failures++;
      $display("FAIL neuron_load: got mask %b at %0d want 100 at 25", load_mask, load_k);
    end
    checks++;
    if (latency != 26 || busy_cnt != 25) begin
      failures++;
      $display("FAIL neuron_latency: got done %0d busy %0d want 26/25", latency, busy_cnt);
    end
    checks++;
    if (bad_nt != 0) begin
      failures++;
      $display("FAIL neuron_nontarget_data: got %0d want 0", bad_nt);
    end
  endtask

  task automatic test_synapse();
    logic [127:0] e0, e1;
    for (int i = 0; i < 4; i++)
      for (int f = 0; f < 3; f++) begin
        write_word(0, 0, i, f, 1 + 3*i + f);
        write_word(0, 1, i, f, 16 + 3*i + f);
      end
    e0 = '0; e1 = '0;
    for (int c = 1; c >= 0; c--) begin
      e0 = e0 << 6; e1 = e1 << 6;
      for (int s = 1; s >= 0; s--)
        for (int f = 2; f >= 0; f--) begin
          e0 = (e0 << 6) | 128'(1 + 3*(2*c+s) + f);
          e1 = (e1 << 6) | 128'(16 + 3*(2*c+s) + f);
        end
    end
    run_op(1'b1, 1'b0, -1, 0);
    checks++;
    if (cnt[0] != 84 || cnt[1] != 84 || cnt[2] != 0) begin
      failures++;
      $display("FAIL syn_shift_counts: got %0d/%0d/%0d want 84/84/0", cnt[0], cnt[1], cnt[2]);
    end
    checks++;
    if (stream[0][83:72] !== 12'b000000_001100 || stream[0][5:0] !== 6'd1) begin
      failures++;
      $display("FAIL syn_row0_ends: got head %b tail %b want 000000001100/000001", stream[0][83:72], stream[0][5:0]);
    end
    checks++;
    if (stream[0][83:0] !== e0[83:0]) begin
      failures++;
      $display("FAIL syn_row0_stream: got %h want %h", stream[0][83:0], e0[83:0]);
    end
    checks++;
    if (stream[1][83:0] !== e1[83:0]) begin
      failures++;
      $display("FAIL syn_row1_stream: got %h want %h", stream[1][83:0], e1[83:0]);
    end
    checks++;
    if (load_mask !== 3'b011 || load_k != 85 || latency != 86) begin
      failures++;
      $display("FAIL syn_load_done: got mask %b at %0d done %0d want 011 at 85 done 86", load_mask, load_k, latency);
    end
  endtask

  task automatic test_priority();
    run_op(1'b1, 1'b1, 10, 1);
    checks++;
    if (cnt[0] != 84 || cnt[2] != 0 || latency != 86) begin
      failures++;
      $display("FAIL priority_syn_wins: got %0d/%0d done %0d want 84/0 done 86", cnt[0], cnt[2], latency);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.cfg_shift !== 3'b000) begin
      failures++;
      $display("FAIL priority_busy_start_ignored: got busy %b shift %b want 0/000", bus.busy, bus.cfg_shift);
    end
  endtask

  task automatic test_write_guard();
    run_op(1'b0, 1'b1, 5, 2);
    run_op(1'b0, 1'b1, -1, 0);
    checks++;
    if (stream[2][23:0] !== 24'h002001) begin
      failures++;
      $display("FAIL guard_busy_write: got %h want 002001", stream[2][23:0]);
    end
    write_word(3, 0, 0, 0, 63);
    write_word(3, 1, 1, 1, 63);
    run_op(1'b0, 1'b1, -1, 0);
    checks++;
    if (stream[2][23:0] !== 24'h002001) begin
      failures++;
      $display("FAIL guard_sel3_write: got %h want 002001", stream[2][23:0]);
    end
  endtask

  task automatic test_reset_mid();
    int k, bits, late;
    @(negedge clk);
    bus.start_syn = 1'b1;
    k = 0; bits = 0;
    while (k < 200 && bits < 40) begin
      @(negedge clk);
      k++;
      bus.start_syn = 1'b0;
      if (bus.cfg_shift[0]) bits++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bits != 40 || {bus.busy, bus.done, bus.cfg_data, bus.cfg_shift, bus.cfg_load} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got bits %0d outs %b want 40/0", bits,
               {bus.busy, bus.done, bus.cfg_data, bus.cfg_shift, bus.cfg_load});
    end
    late = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.cfg_load != 3'b000) late++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done || bus.cfg_load != 3'b000) late++;
    end
    checks++;
    if (late != 0) begin
      failures++;
      $display("FAIL reset_mid_no_load_done: got %0d events want 0", late);
    end
    run_op(1'b1, 1'b0, -1, 0);
    checks++;
    if (cnt[0] != 84 || stream[0] !== 128'd0 || stream[1] !== 128'd0) begin
      failures++;
      $display("FAIL reset_mid_zero_stream: got cnt %0d data %h/%h want 84/0/0", cnt[0], stream[0][83:0], stream[1][83:0]);
    end
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback();
    write_word(0, 1, 3, 2, 27);
    @(negedge clk);
    set_addr(0, 1, 3, 2);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    set_addr(0, 0, 0, 0);
    checks++;
    if (bus.rd_data !== 6'd27) begin
      failures++;
      $display("FAIL readback_value: got %0d want 27", bus.rd_data);
    end
    @(negedge clk);
    checks++;
    if (bus.rd_data !== 6'd27) begin
      failures++;
      $display("FAIL readback_hold: got %0d want 27", bus.rd_data);
    end
    set_addr(0, 1, 3, 3);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_data !== 6'd0) begin
      failures++;
      $display("FAIL readback_invalid: got %0d want 0", bus.rd_data);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_neuron();
    test_synapse();
    test_priority();
    test_write_guard();
    test_reset_mid();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
